// File: rtl/bsg_fifos_to_link_scheduler_if.sv
// Handshake bundle between the tx FIFO outputs, the packet scheduler and the outbound link.
// The scheduler uses the master modport and the FIFO/link environment uses the slave modport.
interface bsg_fifos_to_link_scheduler_if #(
  parameter int num_slots_p = 2,
  parameter int width_p     = 32
);
  localparam int src_w_lp = (num_slots_p > 1) ? $clog2(num_slots_p) : 1;

  logic [num_slots_p-1:0]              fifo_v_i;
  logic [num_slots_p-1:0][width_p-1:0] fifo_data_i;
  logic [num_slots_p-1:0]              fifo_yumi_o;
  logic                                link_v_o;
  logic [width_p-1:0]                  link_data_o;
  logic                                link_last_o;
  logic [src_w_lp-1:0]                 link_src_o;
  logic                                link_ready_i;

  modport master (
    input  fifo_v_i, fifo_data_i, link_ready_i,
    output fifo_yumi_o, link_v_o, link_data_o, link_last_o, link_src_o
  );

  modport slave (
    output fifo_v_i, fifo_data_i, link_ready_i,
    input  fifo_yumi_o, link_v_o, link_data_o, link_last_o, link_src_o
  );
endinterface

// File: rtl/bsg_fifos_to_link_scheduler.sv
// Round-robin packet scheduler: locks the link to one tx FIFO slot for a whole packet,
// gated by a packet credit counter with a sticky over-return error flag.
module bsg_fifos_to_link_scheduler #(
  parameter int num_slots_p     = 2,
  parameter int width_p         = 32,
  parameter int words_per_pkt_p = 4,
  parameter int credits_p       = 8
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  bsg_fifos_to_link_scheduler_if.master         link_if,
  input  logic                                  credit_return_i,
  output logic [31:0]                           credits_o,
  output logic                                  credit_err_o
);
  localparam int src_w_lp  = (num_slots_p > 1) ? $clog2(num_slots_p) : 1;
  localparam int cnt_w_lp  = $clog2(words_per_pkt_p + 1);
  localparam int cred_w_lp = $clog2(credits_p + 1);
  localparam logic [cnt_w_lp-1:0]  last_cnt_lp    = cnt_w_lp'(words_per_pkt_p - 1);
  localparam logic [cred_w_lp-1:0] credits_max_lp = cred_w_lp'(credits_p);
  localparam logic [src_w_lp-1:0]  last_slot_lp   = src_w_lp'(num_slots_p - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  state_e                r_state;
  logic [src_w_lp-1:0]   r_grant;
  logic [src_w_lp-1:0]   r_rr_ptr;
  logic [cnt_w_lp-1:0]   r_word_cnt;
  logic [cred_w_lp-1:0]  r_credits;
  logic                  r_credit_err;

  logic [src_w_lp-1:0]   w_pick;
  logic                  w_found;
  logic                  w_hit;
  int                    w_dist;
  int                    w_best;
  logic                  w_grant;
  logic                  w_cur_v;
  logic                  w_link_v;
  logic                  w_xfer;
  logic                  w_last_word;

  // Round-robin search: nearest valid slot at or after r_rr_ptr, modulo num_slots_p.
  always_comb begin
    w_pick  = '0;
    w_best  = num_slots_p;
    w_dist  = 0;
    w_hit   = 1'b0;
    w_found = |link_if.fifo_v_i;
    for (int s = 0; s < num_slots_p; s++) begin
      w_dist = (s >= int'(r_rr_ptr)) ? (s - int'(r_rr_ptr))
                                     : (s + num_slots_p - int'(r_rr_ptr));
      w_hit  = link_if.fifo_v_i[s] && (w_dist < w_best);
      w_pick = w_hit ? src_w_lp'(s) : w_pick;
      w_best = w_hit ? w_dist : w_best;
    end
  end

  // Link-side datapath: zero-latency pass-through from the locked slot.
  always_comb begin
    w_cur_v     = link_if.fifo_v_i[r_grant];
    w_link_v    = (r_state == ST_BURST) && w_cur_v;
    w_xfer      = w_link_v && link_if.link_ready_i;
    w_last_word = (r_word_cnt == last_cnt_lp);
    w_grant     = (r_state == ST_IDLE) && (r_credits != '0) && w_found;
    if (w_xfer) begin
      link_if.fifo_yumi_o = num_slots_p'(1) << r_grant;
    end else begin
      link_if.fifo_yumi_o = '0;
    end
  end

  assign link_if.link_v_o    = w_link_v;
  assign link_if.link_data_o = link_if.fifo_data_i[r_grant];
  assign link_if.link_last_o = w_link_v && w_last_word;
  assign link_if.link_src_o  = r_grant;
  assign credits_o           = 32'(r_credits);
  assign credit_err_o        = r_credit_err;

  // Scheduler FSM plus credit accounting; a grant and a return in one cycle cancel out.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_rr_ptr     <= '0;
      r_word_cnt   <= '0;
      r_credits    <= credits_max_lp;
      r_credit_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_grant <= w_pick;
            r_state <= ST_BURST;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_BURST: begin
          if (w_xfer && w_last_word) begin
            r_word_cnt <= '0;
            r_rr_ptr   <= (r_grant == last_slot_lp) ? '0 : (r_grant + src_w_lp'(1));
            r_state    <= ST_IDLE;
          end else if (w_xfer) begin
            r_word_cnt <= r_word_cnt + cnt_w_lp'(1);
          end else begin
            r_state <= ST_BURST;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase

      if (w_grant && !credit_return_i) begin
        r_credits <= r_credits - cred_w_lp'(1);
      end else if (!w_grant && credit_return_i) begin
        if (r_credits == credits_max_lp) begin
          r_credit_err <= 1'b1;
        end else begin
          r_credits <= r_credits + cred_w_lp'(1);
        end
      end else begin
        r_credits <= r_credits;
      end
    end
  end

  bsg_fifos_to_link_scheduler_chk #(
    .num_slots_p (num_slots_p),
    .cred_w_p    (cred_w_lp),
    .credits_p   (credits_p)
  ) u_chk (
    .clk_i           (clk_i),
    .reset_n_i       (reset_n_i),
    .fifo_yumi_i     (link_if.fifo_yumi_o),
    .credits_i       (r_credits),
    .credit_return_i (credit_return_i)
  );
endmodule

// Invariants: at most one FIFO dequeued per cycle, credit count in range and never wrapping below zero.
module bsg_fifos_to_link_scheduler_chk #(
  parameter int num_slots_p = 2,
  parameter int cred_w_p    = 4,
  parameter int credits_p   = 8
) (
  input logic                   clk_i,
  input logic                   reset_n_i,
  input logic [num_slots_p-1:0] fifo_yumi_i,
  input logic [cred_w_p-1:0]    credits_i,
  input logic                   credit_return_i
);
  a_yumi_onehot0: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    $onehot0(fifo_yumi_i));

  a_credit_range: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    credits_i <= cred_w_p'(credits_p));

  a_no_underflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    ((credits_i == '0) && !credit_return_i) |=> (credits_i == '0));
endmodule

// File: tb/tb_bsg_fifos_to_link_scheduler.sv
// Bench for bsg_fifos_to_link_scheduler: a vector table for the single-packet and credit
// cases, then queue-backed FIFOs checked every cycle against a packet-level reference model.
module tb_bsg_fifos_to_link_scheduler;
  localparam int NS  = 2;
  localparam int W   = 32;
  localparam int WPP = 4;
  localparam int CP  = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        credit_return;
  logic [31:0] credits;
  logic        credit_err;

  always #5 clk = ~clk;

  bsg_fifos_to_link_scheduler_if #(.num_slots_p(NS), .width_p(W)) u_if ();

  bsg_fifos_to_link_scheduler #(
    .num_slots_p(NS), .width_p(W), .words_per_pkt_p(WPP), .credits_p(CP)
  ) u_dut (
    .clk_i           (clk),
    .reset_n_i       (reset_n),
    .link_if         (u_if),
    .credit_return_i (credit_return),
    .credits_o       (credits),
    .credit_err_o    (credit_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- FIFO contents and reference model ----------------
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  int           m_owner, m_sent, m_credits, m_next;
  bit           m_err;
  int           log_src[$];
  logic [W-1:0] log_data[$];
  bit           log_last[$];

  function automatic int q_size(input int s);
    return (s == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [W-1:0] q_front(input int s);
    return (s == 0) ? q0[0] : q1[0];
  endfunction

  task automatic q_push(input int s, input logic [W-1:0] d);
    if (s == 0) q0.push_back(d);
    else q1.push_back(d);
  endtask

  task automatic q_pop(input int s);
    if (s == 0) void'(q0.pop_front());
    else void'(q1.pop_front());
  endtask

  // One clock of stimulus from the queues; cret_mode 0 none, 1 pulse, 2 on each last-word transfer.
  task automatic cycle(input bit rdy, input int cret_mode);
    bit           ev, el, gnt, cret;
    logic [W-1:0] ed;
    logic [1:0]   ey;
    @(negedge clk);
    for (int s = 0; s < NS; s++) begin
      u_if.fifo_v_i[s]    = (q_size(s) > 0);
      u_if.fifo_data_i[s] = (q_size(s) > 0) ? q_front(s) : 32'h0;
    end
    u_if.link_ready_i = rdy;
    ev   = (m_owner >= 0) && (q_size(m_owner) > 0);
    ed   = ev ? q_front(m_owner) : 32'h0;
    el   = ev && (m_sent == WPP - 1);
    ey   = (ev && rdy) ? (2'b01 << m_owner) : 2'b00;
    cret = (cret_mode == 1) || ((cret_mode == 2) && el && rdy);
    credit_return = cret;
    #1;
    chk("link_v", 64'(u_if.link_v_o), 64'(ev));
    if (ev) chk("link_data", 64'(u_if.link_data_o), 64'(ed));
    chk("link_last", 64'(u_if.link_last_o), 64'(el));
    if (m_owner >= 0) chk("link_src", 64'(u_if.link_src_o), 64'(m_owner));
    chk("yumi", 64'(u_if.fifo_yumi_o), 64'(ey));
    chk("credits", 64'(credits), 64'(m_credits));
    chk("credit_err", 64'(credit_err), 64'(m_err));

    gnt = (m_owner < 0) && (m_credits > 0) && ((q_size(0) > 0) || (q_size(1) > 0));
    if (ev && rdy) begin
      log_src.push_back(m_owner);
      log_data.push_back(ed);
      log_last.push_back(el);
      q_pop(m_owner);
      m_sent++;
      if (m_sent == WPP) begin
        m_next  = (m_owner + 1) % NS;
        m_owner = -1;
        m_sent  = 0;
      end
    end else if (gnt) begin
      for (int i = 0; i < NS; i++) begin
        if ((m_owner < 0) && (q_size((m_next + i) % NS) > 0)) m_owner = (m_next + i) % NS;
      end
    end
    if (gnt && !cret) m_credits--;
    else if (!gnt && cret) begin
      if (m_credits == CP) m_err = 1'b1;
      else m_credits++;
    end
  endtask

  // Asynchronous reset assertion away from any clock edge, outputs checked before the next edge.
  task automatic do_reset(input bit keep_inputs);
    @(negedge clk);
    if (!keep_inputs) begin
      u_if.fifo_v_i = '0;
      credit_return = 1'b0;
    end
    #2 reset_n = 1'b0;
    #1;
    chk("rst_link_v", 64'(u_if.link_v_o), 64'd0);
    chk("rst_yumi", 64'(u_if.fifo_yumi_o), 64'd0);
    chk("rst_last", 64'(u_if.link_last_o), 64'd0);
    chk("rst_src", 64'(u_if.link_src_o), 64'd0);
    chk("rst_credits", 64'(credits), 64'(CP));
    chk("rst_err", 64'(credit_err), 64'd0);
    repeat (2) @(negedge clk);
    u_if.fifo_v_i      = '0;
    u_if.link_ready_i  = 1'b0;
    credit_return      = 1'b0;
    reset_n            = 1'b1;
    m_owner = -1; m_sent = 0; m_credits = CP; m_next = 0; m_err = 1'b0;
    log_src.delete(); log_data.delete(); log_last.delete();
  endtask

  function automatic logic [W-1:0] wd(input int tag, input int s, input int j);
    return 32'(tag) << 24 | 32'(s) << 16 | 32'(j);
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  v;
    logic [31:0] d0;
    logic        rdy;
    logic        cret;
    logic        exp_v;
    logic [31:0] exp_d;
    logic        exp_last;
    logic [1:0]  exp_yumi;
    logic [31:0] exp_cred;
    logic        exp_err;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_n           = 1'b1;
    credit_return     = 1'b0;
    u_if.fifo_v_i     = '0;
    u_if.fifo_data_i  = '0;
    u_if.link_ready_i = 1'b0;

    // Slot0 packet A0..A3 (grant cycle, four words, then idle), then credit returns incl. over-return.
    tbl[0]  = '{2'b01, 32'hA0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 2'b00, 32'd8, 1'b0};
    tbl[1]  = '{2'b01, 32'hA0, 1'b1, 1'b0, 1'b1, 32'hA0, 1'b0, 2'b01, 32'd7, 1'b0};
    tbl[2]  = '{2'b01, 32'hA1, 1'b1, 1'b0, 1'b1, 32'hA1, 1'b0, 2'b01, 32'd7, 1'b0};
    tbl[3]  = '{2'b01, 32'hA2, 1'b1, 1'b0, 1'b1, 32'hA2, 1'b0, 2'b01, 32'd7, 1'b0};
    tbl[4]  = '{2'b01, 32'hA3, 1'b1, 1'b0, 1'b1, 32'hA3, 1'b1, 2'b01, 32'd7, 1'b0};
    tbl[5]  = '{2'b00, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 2'b00, 32'd7, 1'b0};
    tbl[6]  = '{2'b00, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 2'b00, 32'd7, 1'b0};
    tbl[7]  = '{2'b00, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 2'b00, 32'd8, 1'b0};
    tbl[8]  = '{2'b00, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 2'b00, 32'd8, 1'b1};
    tbl[9]  = '{2'b00, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 2'b00, 32'd8, 1'b1};
    tbl[10] = '{2'b00, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 2'b00, 32'd8, 1'b1};

    do_reset(1'b0);
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      u_if.fifo_v_i       = tbl[k].v;
      u_if.fifo_data_i[0] = tbl[k].d0;
      u_if.fifo_data_i[1] = 32'hDEAD_BEEF;
      u_if.link_ready_i   = tbl[k].rdy;
      credit_return       = tbl[k].cret;
      #1;
      chk($sformatf("tbl%0d_v", k), 64'(u_if.link_v_o), 64'(tbl[k].exp_v));
      if (tbl[k].exp_v) begin
        chk($sformatf("tbl%0d_data", k), 64'(u_if.link_data_o), 64'(tbl[k].exp_d));
        chk($sformatf("tbl%0d_src", k), 64'(u_if.link_src_o), 64'd0);
      end
      chk($sformatf("tbl%0d_last", k), 64'(u_if.link_last_o), 64'(tbl[k].exp_last));
      chk($sformatf("tbl%0d_yumi", k), 64'(u_if.fifo_yumi_o), 64'(tbl[k].exp_yumi));
      chk($sformatf("tbl%0d_cred", k), 64'(credits), 64'(tbl[k].exp_cred));
      chk($sformatf("tbl%0d_err", k), 64'(credit_err), 64'(tbl[k].exp_err));
    end

    // Both slots with 8 words, credit back on every last word: packets alternate 0,1,0,1.
    do_reset(1'b0);
    q0.delete(); q1.delete();
    for (int j = 0; j < 8; j++) begin q_push(0, wd(2, 0, j)); q_push(1, wd(2, 1, j)); end
    repeat (24) cycle(1'b1, 2);
    chk("alt_count", 64'(log_src.size()), 64'd16);
    for (int k = 0; k < 16 && k < log_src.size(); k++) begin
      chk("alt_src", 64'(log_src[k]), 64'((k / 4) % 2));
      chk("alt_data", 64'(log_data[k]), 64'(wd(2, (k / 4) % 2, ((k / 8) * 4) + (k % 4))));
    end
    chk("alt_credits", 64'(credits), 64'(CP));

    // Credits exhausted: exactly CP packets, then stall, then one return gives one packet.
    do_reset(1'b0);
    q0.delete(); q1.delete();
    for (int j = 0; j < 40; j++) begin q_push(0, wd(3, 0, j)); q_push(1, wd(3, 1, j)); end
    repeat (50) cycle(1'b1, 0);
    chk("cr_words", 64'(log_src.size()), 64'(CP * WPP));
    chk("cr_zero", 64'(credits), 64'd0);
    repeat (10) cycle(1'b1, 0);
    chk("cr_stall", 64'(log_src.size()), 64'(CP * WPP));
    cycle(1'b1, 1);
    repeat (14) cycle(1'b1, 0);
    chk("cr_one_more", 64'(log_src.size()), 64'((CP + 1) * WPP));
    chk("cr_zero2", 64'(credits), 64'd0);

    // Slot1 runs dry after two words while slot0 waits: lock holds, slot0 only afterwards.
    do_reset(1'b0);
    q0.delete(); q1.delete();
    q_push(1, wd(4, 1, 0)); q_push(1, wd(4, 1, 1));
    repeat (3) cycle(1'b1, 0);
    for (int j = 0; j < 4; j++) q_push(0, wd(4, 0, j));
    repeat (4) cycle(1'b1, 0);
    chk("dry_hold_src", 64'(u_if.link_src_o), 64'd1);
    chk("dry_hold_v", 64'(u_if.link_v_o), 64'd0);
    chk("dry_hold_cnt", 64'(log_src.size()), 64'd2);
    q_push(1, wd(4, 1, 2)); q_push(1, wd(4, 1, 3));
    repeat (12) cycle(1'b1, 0);
    chk("dry_count", 64'(log_src.size()), 64'd8);
    for (int k = 0; k < 8 && k < log_src.size(); k++) begin
      chk("dry_src", 64'(log_src[k]), 64'((k < 4) ? 1 : 0));
      chk("dry_data", 64'(log_data[k]), 64'(wd(4, (k < 4) ? 1 : 0, k % 4)));
    end

    // Reset after word 2 of a slot0 packet; next grant restarts at slot0 with a fresh word count.
    do_reset(1'b0);
    q0.delete(); q1.delete();
    for (int j = 0; j < 4; j++) begin q_push(0, wd(6, 0, j)); q_push(1, wd(6, 1, j)); end
    repeat (3) cycle(1'b1, 0);
    chk("mid_words", 64'(log_src.size()), 64'd2);
    do_reset(1'b1);
    repeat (6) cycle(1'b1, 0);
    for (int j = 4; j < 6; j++) q_push(0, wd(6, 0, j));
    repeat (12) cycle(1'b1, 0);
    chk("post_rst_count", 64'(log_src.size()), 64'd8);
    if (log_src.size() >= 5) begin
      chk("post_rst_src", 64'(log_src[0]), 64'd0);
      chk("post_rst_data", 64'(log_data[0]), 64'(wd(6, 0, 2)));
      chk("post_rst_last", 64'(log_last[3]), 64'd1);
      chk("post_rst_next", 64'(log_src[4]), 64'd1);
    end

    // Random traffic, backpressure and credit returns against the reference model.
    do_reset(1'b0);
    q0.delete(); q1.delete();
    for (int c = 0; c < 3000; c++) begin
      for (int s = 0; s < NS; s++) begin
        if ((q_size(s) < 8) && ($urandom_range(0, 2) == 0)) q_push(s, $urandom);
      end
      cycle($urandom_range(0, 3) != 0, ($urandom_range(0, 5) == 0) ? 1 : 0);
    end
    chk("rand_progress", 64'(log_src.size() > 200), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
